// File: rtl/memory_access_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Ports: fetch_* and data_* requesters, memory_* bus, busy and grant_is_data status.
module memory_access_arbiter #(
  parameter int DATA_WIDTH             = 32,
  parameter int ADDRESS_WIDTH          = 16,
  parameter int MEMORY_LATENCY         = 2,
  parameter int FETCH_STARVATION_LIMIT = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [DATA_WIDTH-1:0]    fetch_data,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0]    data_write_value,
  output logic                     data_ready,
  output logic [DATA_WIDTH-1:0]    data_read_value,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic                     memory_write_enable,
  output logic [DATA_WIDTH-1:0]    memory_write_value,
  input  logic [DATA_WIDTH-1:0]    memory_read_value,
  output logic                     busy,
  output logic                     grant_is_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] LATENCY = 4'(MEMORY_LATENCY);
  localparam logic [3:0] LIMIT   = 4'(FETCH_STARVATION_LIMIT);

  state_t                   state;
  state_t                   state_next;
  logic [3:0]               wait_count;
  logic [3:0]               wait_next;
  logic [3:0]               starve_count;
  logic [3:0]               starve_next;
  logic                     access_write;
  logic                     write_next;
  logic                     owner_next;
  logic [ADDRESS_WIDTH-1:0] address_next;
  logic                     write_enable_next;
  logic [DATA_WIDTH-1:0]    write_value_next;
  logic                     fetch_ready_next;
  logic                     data_ready_next;
  logic [DATA_WIDTH-1:0]    fetch_data_next;
  logic [DATA_WIDTH-1:0]    read_value_next;

  logic data_grant;
  logic fetch_grant;

  // Data wins unless a waiting fetch has been passed over LIMIT times.
  assign data_grant  = data_request &&
                       !(fetch_request && starve_count == LIMIT);
  assign fetch_grant = fetch_request && !data_grant;

  assign busy = (state != IDLE);

  always_comb begin
    state_next        = state;
    wait_next         = wait_count;
    starve_next       = starve_count;
    write_next        = access_write;
    owner_next        = grant_is_data;
    address_next      = memory_address;
    write_value_next  = memory_write_value;
    write_enable_next = 1'b0;
    fetch_ready_next  = 1'b0;
    data_ready_next   = 1'b0;
    fetch_data_next   = fetch_data;
    read_value_next   = data_read_value;
    unique case (state)
      IDLE: begin
        if (data_grant || fetch_grant) begin
          state_next        = ACCESS;
          wait_next         = LATENCY;
          owner_next        = data_grant;
          write_next        = data_grant && data_write;
          write_enable_next = data_grant && data_write;
          write_value_next  = data_write_value;
          address_next      = data_grant ? data_address
                                         : fetch_address;
          if (fetch_grant || !fetch_request) begin
            starve_next = '0;
          end else if (starve_count != LIMIT) begin
            starve_next = starve_count + 4'd1;
          end
        end
      end
      ACCESS: begin
        wait_next = wait_count - 4'd1;
        if (wait_count == 4'd1) begin
          state_next = DONE;
          if (grant_is_data) begin
            data_ready_next = 1'b1;
            // Stores leave the load result register alone.
            if (!access_write) begin
              read_value_next = memory_read_value;
            end
          end else begin
            fetch_ready_next = 1'b1;
            fetch_data_next  = memory_read_value;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      wait_count          <= '0;
      starve_count        <= '0;
      access_write        <= 1'b0;
      grant_is_data       <= 1'b0;
      memory_address      <= '0;
      memory_write_enable <= 1'b0;
      memory_write_value  <= '0;
      fetch_ready         <= 1'b0;
      data_ready          <= 1'b0;
      fetch_data          <= '0;
      data_read_value     <= '0;
    end else begin
      state               <= state_next;
      wait_count          <= wait_next;
      starve_count        <= starve_next;
      access_write        <= write_next;
      grant_is_data       <= owner_next;
      memory_address      <= address_next;
      memory_write_enable <= write_enable_next;
      memory_write_value  <= write_value_next;
      fetch_ready         <= fetch_ready_next;
      data_ready          <= data_ready_next;
      fetch_data          <= fetch_data_next;
      data_read_value     <= read_value_next;
    end
  end

endmodule
